// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter constants.
package gray_pkg;

  // Widest counter supported; helper functions work at this width.
  localparam int unsigned MAX_W = 16;

  // Values for the SATURATE parameter of gray_counter.
  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // What the counter does on a given edge.
  typedef enum logic [1:0] {
    ActHold,
    ActLoad,
    ActStep,
    ActWrap
  } act_e;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Prefix-XOR from the MSB down; zero-extended inputs decode correctly.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_conv.sv
// Combinational binary/Gray converter; TO_GRAY selects the direction.
module gray_conv
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter bit          TO_GRAY = 1'b1
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (TO_GRAY) begin : g_to_gray
    assign data_o = WIDTH'(bin2gray(MAX_W'(data_i)));
  end else begin : g_to_bin
    assign data_o = WIDTH'(gray2bin(MAX_W'(data_i)));
  end

endmodule

// File: rtl/gray_counter.sv
// Registered Gray-code up/down counter with Gray-coded parallel load,
// wrap-or-saturate policy and terminal-count flags.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] load_bin;
  logic             wrap_q, wrap_d;
  logic             at_end;
  act_e             act;

  // Load path: decode the Gray-coded load value to binary.
  gray_conv #(
    .WIDTH   (WIDTH),
    .TO_GRAY (1'b0)
  ) u_load_conv (
    .data_i (load_gray),
    .data_o (load_bin)
  );

  // Output path: encode the next count so gray_q is registered with bin_q.
  gray_conv #(
    .WIDTH   (WIDTH),
    .TO_GRAY (1'b1)
  ) u_out_conv (
    .data_i (bin_d),
    .data_o (gray_d)
  );

  // Count sits at the end of the range for the current direction.
  assign at_end = up ? (bin_q == MaxVal) : (bin_q == '0);
  assign tc     = at_end;

  // Decide this edge's action; load beats en, saturation turns a wrap into a hold.
  always_comb begin
    act = ActHold;
    if (load) begin
      act = ActLoad;
    end else if (en) begin
      if (!at_end) begin
        act = ActStep;
      end else if (SATURATE == MODE_SAT) begin
        act = ActHold;
      end else begin
        act = ActWrap;
      end
    end
  end

  // Next binary count and wrap pulse from the chosen action.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    unique case (act)
      ActLoad: bin_d = load_bin;
      ActStep: bin_d = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
      ActWrap: begin
        bin_d  = up ? '0 : MaxVal;
        wrap_d = 1'b1;
      end
      default: bin_d = bin_q;
    endcase
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: three instances (3-bit wrap, 3-bit saturate,
// 8-bit wrap) checked every cycle against an integer model, plus literal checks.
module tb_gray_counter;

  logic       clk;
  logic       rst;
  logic       en_v   [3];
  logic       up_v   [3];
  logic       load_v [3];
  logic [2:0] lg0, lg1;
  logic [7:0] lg2;
  logic [2:0] g0, b0, g1, b1;
  logic [7:0] g2, b2;
  logic       tc_v   [3];
  logic       wrap_v [3];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  // Behavioural model: plain integer count per instance.
  int unsigned wv [3] = '{3, 3, 8};
  bit          sv [3] = '{1'b0, 1'b1, 1'b0};
  int          mb    [3];
  bit          mwrap [3];
  bit          mstep [3];
  int          prev_g [3];

  int seq_up [8] = '{1, 3, 2, 6, 7, 5, 4, 0};
  int seq_dn [4] = '{4, 5, 7, 6};

  gray_counter #(.WIDTH(3), .SATURATE(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en_v[0]), .up(up_v[0]), .load(load_v[0]), .load_gray(lg0),
    .gray_out(g0), .bin_out(b0), .tc(tc_v[0]), .wrap(wrap_v[0])
  );
  gray_counter #(.WIDTH(3), .SATURATE(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en_v[1]), .up(up_v[1]), .load(load_v[1]), .load_gray(lg1),
    .gray_out(g1), .bin_out(b1), .tc(tc_v[1]), .wrap(wrap_v[1])
  );
  gray_counter #(.WIDTH(8), .SATURATE(0)) u_dut2 (
    .clk(clk), .rst(rst), .en(en_v[2]), .up(up_v[2]), .load(load_v[2]), .load_gray(lg2),
    .gray_out(g2), .bin_out(b2), .tc(tc_v[2]), .wrap(wrap_v[2])
  );

  always #5 clk = ~clk;

  function automatic int dut_bin(int i);
    case (i)
      0: return int'(b0);
      1: return int'(b1);
      default: return int'(b2);
    endcase
  endfunction

  function automatic int dut_gray(int i);
    case (i)
      0: return int'(g0);
      1: return int'(g1);
      default: return int'(g2);
    endcase
  endfunction

  function automatic int lg_of(int i);
    case (i)
      0: return int'(lg0);
      1: return int'(lg1);
      default: return int'(lg2);
    endcase
  endfunction

  function automatic int gray_of(int b);
    return b ^ (b >> 1);
  endfunction

  // Decode by search: the binary value whose Gray code matches.
  function automatic int decode_gray(int g, int unsigned w);
    for (int b = 0; b < (1 << w); b++) begin
      if (gray_of(b) == g) return b;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Apply one clock edge's worth of rules to the model.
  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      int mx;
      mx       = (1 << wv[i]) - 1;
      mwrap[i] = 1'b0;
      mstep[i] = 1'b0;
      if (rst) begin
        mb[i] = 0;
      end else if (load_v[i]) begin
        mb[i] = decode_gray(lg_of(i), wv[i]);
      end else if (en_v[i]) begin
        if (up_v[i]) begin
          if (mb[i] < mx) begin
            mb[i]++;
            mstep[i] = 1'b1;
          end else if (!sv[i]) begin
            mb[i]    = 0;
            mwrap[i] = 1'b1;
            mstep[i] = 1'b1;
          end
        end else begin
          if (mb[i] > 0) begin
            mb[i]--;
            mstep[i] = 1'b1;
          end else if (!sv[i]) begin
            mb[i]    = mx;
            mwrap[i] = 1'b1;
            mstep[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
  endtask

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (chk_on) begin
        int mx;
        int exp_tc;
        mx     = (1 << wv[i]) - 1;
        exp_tc = up_v[i] ? int'(mb[i] == mx) : int'(mb[i] == 0);
        check($sformatf("bin%0d", i), dut_bin(i), mb[i]);
        check($sformatf("gray%0d", i), dut_gray(i), gray_of(mb[i]));
        check($sformatf("wrap%0d", i), int'(wrap_v[i]), int'(mwrap[i]));
        check($sformatf("tc%0d", i), int'(tc_v[i]), exp_tc);
        if (mstep[i]) begin
          check($sformatf("onebit%0d", i), $countones(dut_gray(i) ^ prev_g[i]), 1);
        end
      end
      prev_g[i] = dut_gray(i);
    end
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en_v[i]   = 1'b0;
      up_v[i]   = 1'b0;
      load_v[i] = 1'b0;
      mb[i]     = 0;
      mwrap[i]  = 1'b0;
      mstep[i]  = 1'b0;
      prev_g[i] = 0;
    end
    lg0 = '0;
    lg1 = '0;
    lg2 = '0;

    #12;
    check("reset_bin", int'(b0), 0);
    check("reset_gray", int'(g0), 0);
    check("reset_wrap", int'(wrap_v[0]), 0);
    check("reset_tc_down", int'(tc_v[0]), 1);
    up_v[0] = 1'b1;
    #1;
    check("reset_tc_up", int'(tc_v[0]), 0);

    rst    = 1'b0;
    chk_on = 1'b1;
    en_v[0] = 1'b1;
    en_v[1] = 1'b1;
    up_v[1] = 1'b1;

    // Count up through the full range, wrapping on the 8th step.
    for (int i = 0; i < 8; i++) begin
      check("up_tc", int'(tc_v[0]), (i == 7) ? 1 : 0);
      tick();
      check("up_gray", int'(g0), seq_up[i]);
      check("up_wrap", int'(wrap_v[0]), (i == 7) ? 1 : 0);
    end
    check("sat_top_gray", int'(g1), 4);
    check("sat_top_wrap", int'(wrap_v[1]), 0);

    // Count down from 0 with wrap; saturating instance keeps pushing up.
    up_v[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("dn_gray", int'(g0), seq_dn[j]);
      check("dn_wrap", int'(wrap_v[0]), (j == 0) ? 1 : 0);
      check("sat_hold_gray", int'(g1), 4);
      check("sat_hold_wrap", int'(wrap_v[1]), 0);
    end
    en_v[0] = 1'b0;

    // Saturating instance: load 0, then push down.
    load_v[1] = 1'b1;
    lg1       = 3'b000;
    tick();
    load_v[1] = 1'b0;
    up_v[1]   = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("sat_low_gray", int'(g1), 0);
      check("sat_low_wrap", int'(wrap_v[1]), 0);
      check("sat_low_tc", int'(tc_v[1]), 1);
    end
    en_v[1] = 1'b0;

    // Load beats en; count was 4 so a step would have shown 5.
    load_v[0] = 1'b1;
    lg0       = 3'b110;
    en_v[0]   = 1'b1;
    up_v[0]   = 1'b1;
    tick();
    check("load_bin", int'(b0), 4);
    check("load_gray", int'(g0), 6);
    load_v[0] = 1'b0;
    tick();
    check("after_load_gray", int'(g0), 7);
    check("after_load_bin", int'(b0), 5);

    // Asynchronous reset mid-cycle at count 5.
    en_v[0] = 1'b0;
    tick();
    #1;
    rst = 1'b1;
    model_update();
    #1;
    check("async_rst_bin", int'(b0), 0);
    check("async_rst_gray", int'(g0), 0);
    check("async_rst_wrap", int'(wrap_v[0]), 0);
    tick();
    rst     = 1'b0;
    en_v[0] = 1'b1;
    up_v[0] = 1'b1;
    tick();
    check("post_rst_gray", int'(g0), 1);
    check("post_rst_bin", int'(b0), 1);

    // Random traffic on all instances.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 3; i++) begin
        load_v[i] = ($urandom_range(15) == 0);
        en_v[i]   = ($urandom_range(3) != 0);
        up_v[i]   = 1'($urandom_range(1));
      end
      lg0 = 3'($urandom);
      lg1 = 3'($urandom);
      lg2 = 8'($urandom);
      tick();
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
